i2c_reg_controller: RTL and testbench

- Sequences the byte stream from the I2C bus interface into register-file accesses for the LED controller.
- Decodes the device-address byte and the register pointer byte, with optional auto-increment.
- Issues write strobes and read strobes, and returns read data to the bus interface for transmission.
- Sits between the I2C bus interface and the LED register file in the led_driver top; runs on the 400 kHz oscillator clock.

---
 rtl/i2c_reg_controller.sv | 113 +++++++++++
 tb/tb_i2c_reg_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_controller.sv
// Turns the I2C slave byte stream into register-file write/read strobes and returns read bytes for transmission.
// Write strobes fire in the cycle the data byte arrives. tx_req comes 2+ cycles after a read fetch and waits while tx_ready is low.
`timescale 1ns/1ps
module i2c_reg_controller #(
  parameter logic [6:0] DEV_ADDR = 7'h62,
  parameter int         NUM_REGS = 8,
  parameter int         AI_BIT   = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        rx_start,
  input  logic                        rx_stop,
  input  logic                        tx_ready,
  input  logic                        tx_nack,
  input  logic [7:0]                  reg_rdata,
  output logic [7:0]                  tx_data,
  output logic                        tx_req,
  output logic [$clog2(NUM_REGS)-1:0] reg_addr,
  output logic [7:0]                  reg_wdata,
  output logic                        reg_write,
  output logic                        reg_read,
  output logic                        ack_en,
  output logic                        busy
);

  localparam int PW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DEV_ADDR, ST_REG_PTR, ST_WR_DATA,
    ST_RD_FETCH, ST_RD_LOAD, ST_RD_SEND, ST_IGNORE
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic          ai;
  logic          rd_pending;
  logic          no_event;

  // START/STOP/reset preempt the byte handling, so strobes are suppressed in those cycles.
  assign no_event  = !reset && !rx_start && !rx_stop;
  assign reg_write = no_event && (state == ST_WR_DATA) && rx_valid;
  assign reg_read  = no_event && (state == ST_RD_FETCH);
  assign reg_wdata = rx_data;
  assign reg_addr  = ptr;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      ai         <= 1'b0;
      tx_data    <= 8'h00;
      tx_req     <= 1'b0;
      ack_en     <= 1'b0;
      rd_pending <= 1'b0;
    end else begin
      tx_req     <= 1'b0;
      rd_pending <= reg_read;
      if (rx_start) begin
        state  <= ST_DEV_ADDR;
        ack_en <= 1'b1;
      end else if (rx_stop) begin
        state  <= ST_IDLE;
        ack_en <= 1'b0;
      end else begin
        case (state)
          ST_DEV_ADDR: if (rx_valid) begin
            if (rx_data[7:1] != DEV_ADDR) begin
              state  <= ST_IGNORE;
              ack_en <= 1'b0;
            end else if (rx_data[0]) begin
              state <= ST_RD_FETCH;
            end else begin
              state <= ST_REG_PTR;
            end
          end
          ST_REG_PTR: if (rx_valid) begin
            ptr   <= rx_data[PW-1:0];
            ai    <= rx_data[AI_BIT];
            state <= ST_WR_DATA;
          end
          ST_WR_DATA: if (rx_valid && ai) ptr <= ptr + 1'b1;
          ST_RD_FETCH: state <= ST_RD_LOAD;
          ST_RD_LOAD: begin
            // Register data is only valid the cycle after the read strobe; hold it while stalled.
            if (rd_pending) tx_data <= reg_rdata;
            if (tx_ready) begin
              tx_req <= 1'b1;
              state  <= ST_RD_SEND;
            end
          end
          ST_RD_SEND: begin
            // tx_ready may still be high in the tx_req cycle; it only means "done" after that.
            if (!tx_req && tx_ready) begin
              if (tx_nack) begin
                state  <= ST_IGNORE;
                ack_en <= 1'b0;
              end else begin
                if (ai) ptr <= ptr + 1'b1;
                state <= ST_RD_FETCH;
              end
            end
          end
          ST_IGNORE: ack_en <= 1'b0;
          default:   state  <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_controller.sv
// Scoreboard bench for i2c_reg_controller: stimulus tasks push expected strobes/bytes, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_i2c_reg_controller;

  localparam logic [6:0] DEV = 7'h62;

  logic       clk = 1'b0;
  logic       reset, rx_valid, rx_start, rx_stop, tx_ready, tx_nack, mem_clr;
  logic [7:0] rx_data, reg_rdata, tx_data, reg_wdata;
  logic [2:0] reg_addr;
  logic       tx_req, reg_write, reg_read, ack_en, busy;

  i2c_reg_controller dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_start(rx_start), .rx_stop(rx_stop), .tx_ready(tx_ready), .tx_nack(tx_nack),
    .reg_rdata(reg_rdata), .tx_data(tx_data), .tx_req(tx_req), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_write(reg_write), .reg_read(reg_read),
    .ack_en(ack_en), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file seen by the DUT; returns garbage except the cycle after a read strobe.
  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    else if (reg_write) mem[reg_addr] <= reg_wdata;
    if (reg_read) reg_rdata <= mem[reg_addr];
    else          reg_rdata <= 8'($urandom);
  end

  typedef struct { int kind; logic [2:0] addr; logic [7:0] data; } ev_t;  // kind 0=write 1=read 2=tx
  ev_t exp_q[$];

  int total = 0;
  int bad   = 0;

  logic [2:0] m_ptr;
  logic       m_ai;
  logic [7:0] m_mem [8];
  logic [7:0] dbuf [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic void push_ev(input int kind, input logic [2:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_write(input logic [7:0] d);
    push_ev(0, m_ptr, d);
    m_mem[m_ptr] = d;
    if (m_ai) m_ptr = m_ptr + 3'd1;
  endfunction

  function automatic void exp_read();
    push_ev(1, m_ptr, 8'h00);
    push_ev(2, 3'd0, m_mem[m_ptr]);
  endfunction

  task automatic pop_check(input int kind, input logic [2:0] a, input logic [7:0] d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%0h expected none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== a || e.data !== d) begin
        bad++;
        $display("FAIL event: got kind=%0d addr=%0d data=%0h expected kind=%0d addr=%0d data=%0h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reg_write) pop_check(0, reg_addr, reg_wdata);
    if (reg_read)  pop_check(1, reg_addr, 8'h00);
    if (tx_req)    pop_check(2, 3'd0, tx_data);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic byte_in(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_start();
    rx_start = 1'b1; tick(); rx_start = 1'b0; tick();
  endtask

  task automatic send_stop();
    rx_stop = 1'b1; tick(); rx_stop = 1'b0;
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("ack_after_stop", 32'(ack_en), 32'd0);
    chk("ptr_after_stop", 32'(reg_addr), 32'(m_ptr));
  endtask

  task automatic wr_txn(input logic [6:0] dev, input logic [7:0] pb, input int n, input bit do_stop);
    bit match = (dev == DEV);
    send_start();
    byte_in({dev, 1'b0}, 1);
    if (!match) chk("ack_en_mismatch", 32'(ack_en), 32'd0);
    if (match) begin m_ptr = pb[2:0]; m_ai = pb[7]; end
    byte_in(pb, 1);
    for (int i = 0; i < n; i++) begin
      if (match) exp_write(dbuf[i]);
      byte_in(dbuf[i], $urandom_range(1, 2));
    end
    if (do_stop) send_stop();
  endtask

  // Master reads n bytes, ACKing all but the last; optional stall keeps tx_ready low during the load.
  task automatic rd_txn(input int n, input bit stall);
    bit ok = 1'b1;
    send_start();
    exp_read();
    if (stall) tx_ready = 1'b0;
    byte_in({DEV, 1'b1}, 0);
    if (stall) begin
      repeat ($urandom_range(2, 4)) tick();
      tx_ready = 1'b1;
    end
    for (int i = 0; i < n && ok; i++) begin
      int w = 0;
      while (!tx_req && w < 50) begin tick(); w++; end
      if (!tx_req) begin
        total++; bad++;
        $display("FAIL tx_req_timeout: got no tx_req after %0d cycles expected tx_req", w);
        ok = 1'b0;
      end else begin
        tx_ready = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        if (i == n - 1) tx_nack = 1'b1;
        else begin
          if (m_ai) m_ptr = m_ptr + 3'd1;
          exp_read();
        end
        tx_ready = 1'b1;
        tick();
        tx_nack = 1'b0;
      end
    end
    tx_ready = 1'b1;
    tick();
    if (ok) chk("ack_en_ignore", 32'(ack_en), 32'd0);
    byte_in(8'($urandom), 1);
    send_stop();
  endtask

  initial begin
    reset = 1'b1; mem_clr = 1'b1; rx_valid = 1'b0; rx_start = 1'b0; rx_stop = 1'b0;
    rx_data = 8'h00; tx_ready = 1'b1; tx_nack = 1'b0;
    m_ptr = 3'd0; m_ai = 1'b0;
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    repeat (3) tick();
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_ack_en", 32'(ack_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ptr", 32'(reg_addr), 32'd0);
    chk("rst_strobes", {29'd0, tx_req, reg_write, reg_read}, 32'd0);
    reset = 1'b0; mem_clr = 1'b0;
    tick();

    dbuf[0] = 8'h11; dbuf[1] = 8'h22;
    wr_txn(DEV, 8'h82, 2, 1'b1);
    dbuf[0] = 8'hA1; dbuf[1] = 8'hB2; dbuf[2] = 8'hC3;
    wr_txn(DEV, 8'h87, 3, 1'b1);
    dbuf[0] = 8'hAA; dbuf[1] = 8'hBB;
    wr_txn(DEV, 8'h05, 2, 1'b1);
    dbuf[0] = 8'h01; dbuf[1] = 8'h55;
    wr_txn(7'h63, 8'h01, 1, 1'b1);

    dbuf[0] = 8'h3C; dbuf[1] = 8'h5A;
    wr_txn(DEV, 8'h81, 2, 1'b1);
    wr_txn(DEV, 8'h81, 0, 1'b0);
    rd_txn(2, 1'b0);
    rd_txn(3, 1'b1);

    // Reset in the middle of a write burst.
    dbuf[0] = 8'h11;
    wr_txn(DEV, 8'h83, 1, 1'b0);
    rx_data = 8'h99; rx_valid = 1'b1; reset = 1'b1;
    tick();
    rx_valid = 1'b0; reset = 1'b0;
    m_ptr = 3'd0; m_ai = 1'b0;
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    chk("midrst_ack_en", 32'(ack_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ptr", 32'(reg_addr), 32'(m_ptr));
    chk("midrst_strobes", {29'd0, tx_req, reg_write, reg_read}, 32'd0);
    tick();

    // START coincident with a data byte: the byte must not be written.
    wr_txn(DEV, 8'h80, 0, 1'b0);
    rx_start = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    tick();
    rx_start = 1'b0; rx_valid = 1'b0;
    chk("start_wins_ack", 32'(ack_en), 32'd1);
    chk("start_wins_busy", 32'(busy), 32'd1);
    dbuf[0] = 8'h66;
    wr_txn(DEV, 8'h86, 1, 1'b1);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        rd_txn($urandom_range(1, 4), 1'($urandom_range(0, 1)));
      end else begin
        int n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) dbuf[i] = 8'($urandom);
        wr_txn(($urandom_range(0, 7) == 0) ? 7'h15 : DEV, 8'($urandom), n, 1'b1);
      end
    end

    repeat (5) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
